// File: rtl/flit_rx_assembler.sv
// flit_rx_assembler
// Reassembles UART receive bytes into one flit. A frame is SYNC_BYTE, then
// FLIT_BYTES payload bytes (first byte ends up in the flit MSBs), then one
// checksum byte equal to the XOR of the payload. A good frame is offered on
// a valid/ready interface. Checksum errors, inter-byte timeouts and bytes
// dropped while a flit waits are reported as single-cycle pulses.
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-low reset
//   rx_data         byte from the UART receiver
//   rx_data_valid   one-cycle strobe qualifying rx_data
//   flit_out        assembled flit, stable while flit_out_valid is high
//   flit_out_valid  flit available, held until accepted
//   flit_out_ready  consumer accepts when valid and ready are both high
//   busy            high while a frame is in progress or a flit is held
//   chk_err         pulse: checksum mismatch
//   timeout_err     pulse: frame abandoned after an inter-byte timeout
//   overrun         pulse: byte dropped while holding an unaccepted flit
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | hunting for SYNC_BYTE, other bytes discarded
// PAYLOAD | shifting in payload bytes and accumulating the XOR checksum
// CHECK   | waiting for the checksum byte
// HOLD    | flit presented, waiting for the handshake

module flit_rx_assembler #(
    parameter int         FLIT_BYTES     = 4,
    parameter logic [7:0] SYNC_BYTE      = 8'h7E,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_data_valid,
    output logic [8*FLIT_BYTES-1:0] flit_out,
    output logic                    flit_out_valid,
    input  logic                    flit_out_ready,
    output logic                    busy,
    output logic                    chk_err,
    output logic                    timeout_err,
    output logic                    overrun
);

    localparam int W  = 8 * FLIT_BYTES;
    localparam int BW = $clog2(FLIT_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [BW-1:0] LAST_BYTE = BW'(FLIT_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t         state;
    logic [W-1:0]   sr;
    logic [BW-1:0]  byte_cnt;
    logic [TW-1:0]  tmo_cnt;
    logic [7:0]     acc;

    wire is_sync = rx_data_valid && (rx_data == SYNC_BYTE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            sr             <= '0;
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
            acc            <= '0;
            flit_out       <= '0;
            flit_out_valid <= 1'b0;
            busy           <= 1'b0;
            chk_err        <= 1'b0;
            timeout_err    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (is_sync) begin
                        state    <= S_PAYLOAD;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        acc      <= '0;
                        tmo_cnt  <= '0;
                    end
                end

                S_PAYLOAD, S_CHECK: begin
                    if (rx_data_valid) begin
                        tmo_cnt <= '0;
                        if (state == S_PAYLOAD) begin
                            // Payload is not escaped: a SYNC_BYTE value here is data.
                            sr       <= (sr << 8) | W'(rx_data);
                            acc      <= acc ^ rx_data;
                            byte_cnt <= byte_cnt + BW'(1);
                            if (byte_cnt == LAST_BYTE)
                                state <= S_CHECK;
                        end else if (rx_data == acc) begin
                            state          <= S_HOLD;
                            flit_out       <= sr;
                            flit_out_valid <= 1'b1;
                        end else begin
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                            chk_err <= 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_HOLD: begin
                    if (flit_out_ready) begin
                        // A byte in the handshake cycle follows IDLE rules.
                        flit_out_valid <= 1'b0;
                        if (is_sync) begin
                            state    <= S_PAYLOAD;
                            byte_cnt <= '0;
                            acc      <= '0;
                            tmo_cnt  <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (rx_data_valid) begin
                        overrun <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/flit_rx_assembler.md
# flit_rx_assembler

Receive-side counterpart of the router's flit-to-UART transmit path. It consumes bytes delivered by the UART receiver (`rx_data` / `rx_data_valid`), finds the start of each frame, and reassembles the payload bytes into one flit. It checks the frame checksum and presents the flit on a valid/ready interface to the router core. Framing errors, inter-byte timeouts and overruns are reported as single-cycle pulses.

## Interface
- `FLIT_BYTES`, 4: payload bytes per flit; flit width is `8*FLIT_BYTES`.
- `SYNC_BYTE`, 8'h7E: start-of-frame marker.
- `TIMEOUT_CYCLES`, 100000: maximum `clk` cycles allowed between consecutive bytes of one frame.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `rx_data` in 8: byte from the UART receiver.
- `rx_data_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `flit_out` out `8*FLIT_BYTES`: assembled flit. The first payload byte occupies the MSBs.
- `flit_out_valid` out 1: flit available; held until accepted.
- `flit_out_ready` in 1: consumer accepts the flit when both valid and ready are high.
- `busy` out 1: high in PAYLOAD, CHECK and HOLD.
- `chk_err` out 1: one-cycle pulse when the checksum mismatches.
- `timeout_err` out 1: one-cycle pulse when a frame is abandoned by timeout.
- `overrun` out 1: one-cycle pulse when a byte is dropped while in HOLD.

## Operation
- **Frame format:** `SYNC_BYTE`, then `FLIT_BYTES` payload bytes, then 1 checksum byte. The checksum is the XOR of all payload bytes.
- **IDLE:**
  - A valid byte equal to `SYNC_BYTE` moves to PAYLOAD, clears the byte counter, the checksum accumulator and the timeout counter.
  - Any other byte is discarded silently.
- **PAYLOAD:**
  - Each valid byte shifts into the shift register from the LSB side (`sr <= {sr[8*FLIT_BYTES-9:0], rx_data}`).
  - Each valid byte is XORed into the accumulator, increments the byte counter and clears the timeout counter.
  - A `SYNC_BYTE` value is treated as data; the payload is not escaped.
  - After byte `FLIT_BYTES` is accepted, move to CHECK.
- **CHECK:** on the next valid byte, compare it with the accumulator.
  - Match: move to HOLD and load `flit_out` from the shift register.
  - Mismatch: pulse `chk_err` and return to IDLE.
- **Timeout:** in PAYLOAD and CHECK the timeout counter increments on every cycle without `rx_data_valid`. When it reaches `TIMEOUT_CYCLES - 1`, pulse `timeout_err` and go to IDLE. Partial data is discarded.
- **HOLD:**
  - `flit_out_valid` = 1 and `flit_out` is stable.
  - When `flit_out_valid && flit_out_ready`, go to IDLE.
  - A valid byte arriving in HOLD while ready is low is dropped and pulses `overrun`.
  - A byte arriving in the same cycle as the handshake is processed with IDLE rules, so a `SYNC_BYTE` moves directly to PAYLOAD.
- **Counter widths:**
  - Byte counter: `$clog2(FLIT_BYTES+1)` bits.
  - Timeout counter: `$clog2(TIMEOUT_CYCLES)` bits, saturating.
  - Checksum accumulator: 8 bits.
- **Reset:** asynchronous reset forces IDLE and clears the shift register, counters and all outputs. Reset mid-frame discards the frame; no error pulse is generated.

## Timing
- **Reset values:** `flit_out` = 0, `flit_out_valid` = 0, `busy` = 0, `chk_err` = 0, `timeout_err` = 0, `overrun` = 0.
- **Latency:** checksum byte accepted in cycle t produces either `flit_out_valid` = 1 or a `chk_err` pulse in cycle t+1, never both.
- **Handshake:**
  - The consumer may hold `flit_out_ready` high permanently.
  - Handshake in cycle u gives `flit_out_valid` = 0 in cycle u+1.
  - Minimum time from valid to the next flit's valid is `FLIT_BYTES`+2 byte strobes.
- **Pulses:** `busy` is registered and tracks state with 1-cycle latency after the state change. `chk_err`, `timeout_err` and `overrun` are registered and exactly 1 cycle wide.
- **Back-to-back strobes:** `rx_data_valid` may be asserted on consecutive cycles; every strobe is consumed in its cycle.

## Test plan
- Bytes 7E 12 34 56 78 08, one per 10 cycles, `flit_out_ready` = 1 → `flit_out` = 32'h12345678 with `flit_out_valid` for exactly 1 cycle, the cycle after byte 08; no error pulses.
- Same frame with checksum 09 → `chk_err` pulses once; `flit_out_valid` stays 0; `busy` returns to 0.
- Bytes AA 55 7E 7E 7E 7E 7E 00 → leading bytes ignored, payload 7E7E7E7E accepted; `flit_out` = 32'h7E7E7E7E.
- `TIMEOUT_CYCLES` = 50; send 7E 12 then no bytes → `timeout_err` pulses after 50 idle cycles; a following valid frame 7E 01 02 03 04 04 yields 32'h01020304.
- `flit_out_ready` = 0; send a valid frame, then byte 7E → `overrun` pulses; `flit_out` unchanged; raising ready completes the handshake.
- Deassert `reset` after the third payload byte, release it, then send a full frame → no error pulse; only the post-reset flit appears.
